uart_module: RTL and testbench
==============================

# uart_module

Self-contained 8N1 UART block with a transmitter and a receiver sharing one clock. A rising edge on `tx_ctr` launches a burst of frames carrying an auto-incrementing byte on `Tx`. The receiver decodes serial frames on `Rx` into `data`. With `Tx` tied to `Rx` at the integration level, the block serves as a loopback self-test core.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 4..65535.
- `FRAMES_PER_BURST`, default 4: frames sent per `tx_ctr` trigger; legal range 1..255.
- `INIT_DATA`, default 8'hA5: reset value of `tx_data`.

Ports:
- `clk`  input  1  single system clock; all logic on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `tx_ctr`  input  1  transmit trigger; its rising edge starts a burst.
- `Rx`  input  1  serial receive line; idles high; asynchronous to `clk`.
- `Tx`  output  1  serial transmit line; idles high; registered.
- `data`  output  8  last correctly framed received byte; registered.
- `tx_data`  output  8  byte currently being sent, or the next byte to send; registered.

## Operation
- Frame format: start bit (0), then 8 data bits LSB first, then stop bit (1), giving 10 bits. Every bit is held for exactly `CLKS_PER_BIT` cycles.
- Reset values: `Tx`=1, `data`=8'h00, `tx_data`=`INIT_DATA`. All FSMs return to IDLE and all counters clear.
- `tx_ctr` edge detect: the previous value is registered. A trigger is `tx_ctr`=1 while the previous value was 0.
  - Holding `tx_ctr` high does not retrigger.
  - A trigger that arrives during a burst is ignored.
- TX FSM states and transitions:
  - IDLE → START on trigger.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bits.
  - STOP → START if frames remain in the burst.
  - STOP → IDLE after the last frame.
- `tx_data` increments by 1, wrapping 8'hFF→8'h00, on the last cycle of each stop bit. It is therefore constant for the whole of each frame.
- Frames within a burst are back-to-back, with no idle gap.
- RX input path: `Rx` passes through a 2-flop synchronizer. All receiver logic uses the synchronized signal.
- RX FSM states and transitions:
  - IDLE → START on a synchronized 1→0 transition.
  - START: re-samples at `CLKS_PER_BIT/2` (integer division). If still 0, go to DATA; if 1, treat as a glitch and go back to IDLE.
  - DATA: samples 8 bits at `CLKS_PER_BIT` intervals and shifts them in LSB first.
  - STOP: samples once. If 1, load `data` with the shifted byte; if 0 (framing error), `data` is unchanged. Either way, go to IDLE.
- TX and RX run independently, so full-duplex operation is legal.

## Timing
- Trigger latency: `Tx` falls on the 2nd rising edge after the edge where `tx_ctr` is first sampled high.
- Burst duration: `FRAMES_PER_BURST*10*CLKS_PER_BIT` cycles. At default parameters this is 160 cycles.
- Loopback latency: `data` updates 3 + 9*`CLKS_PER_BIT` + `CLKS_PER_BIT/2` cycles after `Rx` falls at the start bit, give or take 1 cycle.
- `rst` asserted mid-frame: on the next clock edge, `Tx`=1 and any burst in progress is aborted. A partially received frame is discarded.
- `rst` has priority over a simultaneous trigger.

## Configuration
- `UART_PARITY_EN` defined:
  - An even-parity bit is inserted between bit 7 and the stop bit, giving an 11-bit frame.
  - The receiver checks parity. On a mismatch `data` is not updated, exactly as for a framing error.
- `UART_PARITY_EN` undefined: 8N1 frames as specified above, and no parity logic is built.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → `Tx`=1, `data`=8'h00, `tx_data`=8'hA5.
- Single trigger with `Tx` looped to `Rx`, defaults, `tx_ctr` high for 5 cycles → exactly 4 frames carrying A5, A6, A7, A8. `data` reads A5, A6, A7, A8 in turn. Final `tx_data`=8'hA9, and `Tx` idles high after 160 cycles.
- Trigger during a burst: pulse `tx_ctr` again mid-frame 2 → no extra frames; burst length stays 160 cycles.
- Second trigger after idle → frames carry A9..AC, and `data` ends at 8'hAC.
- Framing error: drive `Rx` with 8'h3C followed by stop bit = 0 → `data` keeps its previous value. A subsequent valid 8'h3C frame → `data`=8'h3C.
- Reset mid-frame: assert `rst` during DATA of frame 1 → `Tx`=1 next cycle, `tx_data`=8'hA5, and `data` is unchanged from 8'h00.

Source files
------------

// File: rtl/uart_module.sv
// uart_module: 8N1 UART with a burst transmitter (auto-incrementing byte)
// and an independent receiver. Tx and Rx share one clock.
// Optional feature macro: UART_PARITY_EN -- adds an even-parity bit between
// data bit 7 and the stop bit on both directions (11-bit frames); the
// receiver drops frames whose parity does not match.
module uart_module #(
    parameter int         CLKS_PER_BIT     = 4,
    parameter int         FRAMES_PER_BURST = 4,
    parameter logic [7:0] INIT_DATA        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ctr,
    input  logic       Rx,
    output logic       Tx,
    output logic [7:0] data,
    output logic [7:0] tx_data
);

    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(FRAMES_PER_BURST - 1);

    // Both FSMs share one encoding; PARITY is only reachable with UART_PARITY_EN.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ---------------- trigger path and RX synchronizer ----------------
    logic ctr_q, ctr_prev_q, trig_q, trig_d;
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // A trigger is tx_ctr seen high while its previous sample was low.
    assign trig_d = ctr_q & ~ctr_prev_q;

    // Input registers: tx_ctr sample, its previous value, the trigger pulse,
    // and the two-flop Rx synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q      <= 1'b0;
            ctr_prev_q <= 1'b0;
            trig_q     <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            ctr_q      <= tx_ctr;
            ctr_prev_q <= ctr_q;
            trig_q     <= trig_d;
            rx_meta_q  <= Rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end

    // ---------------- transmitter ----------------
    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_frame_q, tx_frame_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_q, tx_d;
    logic        tx_bit_end;

    // TX next state; the line value is derived from the next state so that
    // Tx is registered and aligned with the state register.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        tx_data_d  = tx_data_q;
        tx_d       = 1'b1;
        tx_bit_end = (tx_cnt_q == BIT_LAST);

        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = 16'd0;
                if (trig_q) begin
                    tx_state_d = ST_START;
                    tx_frame_d = 8'd0;
                end
            end
            ST_START: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = 16'd0;
                    if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_d = ST_PARITY;
`else
                        tx_state_d = ST_STOP;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (tx_bit_end) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (tx_bit_end) begin
                    // Advance the byte as the stop bit ends so it is stable for a whole frame.
                    tx_cnt_d  = 16'd0;
                    tx_data_d = tx_data_q + 8'd1;
                    if (tx_frame_q == FRAME_LAST) begin
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_frame_d = tx_frame_q + 8'd1;
                        tx_state_d = ST_START;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        case (tx_state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = tx_data_q[tx_bit_d];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = ^tx_data_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // TX state register; reset aborts any burst and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_frame_q <= 8'd0;
            tx_data_q  <= INIT_DATA;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
            tx_data_q  <= tx_data_d;
            tx_q       <= tx_d;
        end
    end

    // ---------------- receiver ----------------
    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_bit_end;
`ifdef UART_PARITY_EN
    logic        rx_par_err_q, rx_par_err_d;
`endif

    // RX next state: mid-start-bit glitch check, then one sample per bit time.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
`ifdef UART_PARITY_EN
        rx_par_err_d = rx_par_err_q;
`endif
        rx_bit_end = (rx_cnt_q == BIT_LAST);

        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_d = ST_PARITY;
`else
                        rx_state_d = ST_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (rx_bit_end) begin
                    rx_cnt_d     = 16'd0;
                    rx_par_err_d = rx_sync_q ^ (^rx_shift_q);
                    rx_state_d   = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (rx_bit_end) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = ST_IDLE;
`ifdef UART_PARITY_EN
                    if (rx_sync_q && !rx_par_err_q) rx_data_d = rx_shift_q;
`else
                    if (rx_sync_q) rx_data_d = rx_shift_q;
`endif
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // RX state register; reset discards any partially received frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
`ifdef UART_PARITY_EN
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
`ifdef UART_PARITY_EN
            rx_par_err_q <= rx_par_err_d;
`endif
        end
    end

    assign Tx      = tx_q;
    assign tx_data = tx_data_q;
    assign data    = rx_data_q;

endmodule

// File: tb/tb_uart_module.sv
// tb_uart_module: randomized bench for uart_module with a frame-level model.
module tb_uart_module;
  localparam int         C     = 4;
  localparam int         F     = 4;
  localparam logic [7:0] INIT  = 8'hA5;
  localparam int         H     = C / 2;
`ifdef UART_PARITY_EN
  localparam int         FB    = 11;
`else
  localparam int         FB    = 10;
`endif
  localparam int FRAME_CYC = FB * C;
  localparam int BURST_CYC = F * FRAME_CYC;
  // Rx falls after edge f; data loads on edge f + RX_LAT.
  localparam int RX_LAT    = 3 + H + (FB - 1) * C;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_ctr = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b1;
  logic       rx_line;
  logic       tx_w;
  logic [7:0] data_w;
  logic [7:0] tx_data_w;

  assign rx_line = loop_en ? tx_w : rx_drv;

  uart_module #(.CLKS_PER_BIT(C), .FRAMES_PER_BURST(F), .INIT_DATA(INIT)) dut (
    .clk(clk), .rst(rst), .tx_ctr(tx_ctr), .Rx(rx_line),
    .Tx(tx_w), .data(data_w), .tx_data(tx_data_w)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  typedef struct { int u; logic [7:0] v; } rx_ev_t;
  rx_ev_t     exp_q[$];
  int         cyc = 0;
  bit         m_valid = 1'b0;
  bit         m_prev = 1'b0;
  int         m_start = 0;
  int         m_end = 0;
  logic [7:0] m_base = INIT;
  logic [7:0] m_data = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;
  int         last_k = 0;

  function automatic logic exp_tx(input int t);
    int off, k, b;
    logic [7:0] byt;
    exp_tx = 1'b1;
    if (t >= m_start && t < m_end) begin
      off = t - m_start;
      k   = off / FRAME_CYC;
      b   = (off % FRAME_CYC) / C;
      byt = 8'(m_base + 8'(k));
      if (b == 0) exp_tx = 1'b0;
      else if (b <= 8) exp_tx = byt[b-1];
`ifdef UART_PARITY_EN
      else if (b == 9) exp_tx = ^byt;
`endif
    end
  endfunction

  function automatic logic [7:0] exp_txd(input int t);
    if (t >= m_start && t < m_end) exp_txd = 8'(m_base + 8'((t - m_start) / FRAME_CYC));
    else exp_txd = m_base;
  endfunction

  // Model advances on each rising edge, seeing the same inputs as the DUT.
  always @(posedge clk) begin
    rx_ev_t ev;
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 1'b1; m_prev = 1'b0; m_start = 0; m_end = 0;
      m_base = INIT; m_data = 8'h00; exp_q.delete();
    end else if (m_valid) begin
      if (m_end != 0 && cyc == m_end) m_base = 8'(m_base + 8'(F));
      if (tx_ctr && !m_prev && cyc + 1 >= m_end) begin
        m_start = cyc + 2;
        m_end   = m_start + BURST_CYC;
        if (loop_en) begin
          for (int i = 0; i < F; i++) begin
            ev.u = m_start + i * FRAME_CYC + RX_LAT;
            ev.v = 8'(m_base + 8'(i));
            exp_q.push_back(ev);
          end
        end
      end
      m_prev = tx_ctr;
      while (exp_q.size() > 0 && exp_q[0].u + 1 < cyc) begin
        m_data = exp_q[0].v;
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Per-cycle compare on the falling edge; data may take either value within +/-1 of its update.
  always @(negedge clk) begin
    if (m_valid) begin
      check8("tx_line", {7'd0, tx_w}, {7'd0, exp_tx(cyc)});
      check8("tx_data", tx_data_w, exp_txd(cyc));
      if (exp_q.size() > 0 && cyc >= exp_q[0].u - 1) begin
        n_cmp++;
        if (data_w !== m_data && data_w !== exp_q[0].v) begin
          n_err++;
          $display("FAIL data_window cyc=%0d actual=%h required=%h_or_%h", cyc, data_w, m_data, exp_q[0].v);
        end
      end else begin
        check8("data", data_w, m_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a falling edge; tx_ctr is sampled high on edges last_k .. last_k+hold-1.
  task automatic trigger(input int hold);
    tx_ctr = 1'b1;
    last_k = cyc + 1;
    repeat (hold) @(negedge clk);
    tx_ctr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_ev_t ev;
    @(negedge clk);
    if (stop) begin
      ev.u = cyc + RX_LAT;
      ev.v = b;
      exp_q.push_back(ev);
    end
    rx_drv = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (C) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx_drv = ^b;
    repeat (C) @(negedge clk);
`endif
    rx_drv = stop;
    repeat (C) @(negedge clk);
    rx_drv = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, s, fall, mode, hold;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check8("reset_tx", {7'd0, tx_w}, 8'h01);
    check8("reset_data", data_w, 8'h00);
    check8("reset_tx_data", tx_data_w, 8'hA5);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during DATA of frame 1.
    trigger(2);
    k = last_k;
    wait_cyc(k + 2 + C + 3);
    rst = 1'b1;
    @(negedge clk);
    check8("midreset_tx", {7'd0, tx_w}, 8'h01);
    check8("midreset_tx_data", tx_data_w, 8'hA5);
    check8("midreset_data", data_w, 8'h00);
    rst = 1'b0;
    repeat (FRAME_CYC) @(negedge clk);

    // Burst 1 in loopback, tx_ctr high 5 cycles, retrigger mid-frame 2.
    tx_ctr = 1'b1;
    k = cyc + 1;
    fall = -1;
    for (int w = 0; w < 12 && fall < 0; w++) begin
      @(negedge clk);
      if (tx_w == 1'b0) fall = cyc;
    end
    n_cmp++;
    if (fall != k + 2) begin
      n_err++;
      $display("FAIL trigger_latency actual=%0d required=2", fall - k);
    end
    wait_cyc(k + 4);
    tx_ctr = 1'b0;
    s = k + 2;
    wait_cyc(s + FRAME_CYC + FRAME_CYC / 2);
    tx_ctr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_ctr = 1'b0;
    wait_cyc(s + BURST_CYC - FRAME_CYC);
    check8("last_start_bit", {7'd0, tx_w}, 8'h00);
    wait_cyc(s + BURST_CYC + 12);
    check8("burst1_idle", {7'd0, tx_w}, 8'h01);
    check8("burst1_tx_data", tx_data_w, 8'hA9);
    check8("burst1_data", data_w, 8'hA8);

    // Burst 2 after idle.
    repeat (10) @(negedge clk);
    trigger(1);
    wait_cyc(last_k + 2 + BURST_CYC + 12);
    check8("burst2_data", data_w, 8'hAC);
    check8("burst2_tx_data", tx_data_w, 8'hAD);

    // Framing error then a good frame.
    loop_en = 1'b0;
    send_rx(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    check8("framing_err_data", data_w, 8'hAC);
    send_rx(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check8("good_frame_data", data_w, 8'h3C);

    // Randomized traffic.
    for (int it = 0; it < 10; it++) begin
      mode = $urandom_range(0, 2);
      hold = $urandom_range(1, 8);
      if (mode == 0) begin
        loop_en = 1'b1;
        @(negedge clk);
        trigger(hold);
        wait_cyc(last_k + 2 + $urandom_range(12, BURST_CYC - 12));
        tx_ctr = 1'b1;
        @(negedge clk);
        tx_ctr = 1'b0;
        wait_cyc(last_k + 2 + BURST_CYC + 15);
      end else if (mode == 1) begin
        loop_en = 1'b0;
        @(negedge clk);
        fork
          trigger(hold);
          begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
            repeat ($urandom_range(2, 10)) @(negedge clk);
            send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
          end
        join
        wait_cyc(last_k + 2 + BURST_CYC + 15);
      end else begin
        loop_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
          send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
          repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
      end
      repeat ($urandom_range(3, 10)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
